// File: rtl/mantissa_sub_normalizer.sv
// Effective-subtraction mantissa path for the FP adder: |a-b| with swap flag,
// then one-bit-per-cycle left normalization with exponent decrement.
module mantissa_sub_normalizer #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [MANT_W-1:0] i_a_mant,
    input  logic [MANT_W-1:0] i_b_mant,
    input  logic [EXP_W-1:0]  i_exp_in,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [MANT_W-1:0] o_diff_mant,
    output logic [EXP_W-1:0]  o_exp_out,
    output logic              o_swap,
    output logic              o_zero,
    output logic              o_underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [MANT_W-1:0] r_a, r_b;
    logic [MANT_W-1:0] r_mant;
    logic [EXP_W-1:0]  r_exp;
    logic              r_swap, r_zero, r_underflow;

    logic [MANT_W:0]   w_sum;
    logic              w_borrow;
    logic [MANT_W-1:0] w_diff;

    // Carry-out of a + ~b + 1 is clear exactly when b > a.
    assign w_sum    = {1'b0, r_a} + {1'b0, ~r_b} + (MANT_W+1)'(1);
    assign w_borrow = ~w_sum[MANT_W];
    assign w_diff   = w_borrow ? (r_b - r_a) : w_sum[MANT_W-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_in_valid) w_next = SUB;
            SUB:  w_next = (w_diff == '0) ? DONE : NORM;
            NORM: if (r_mant[MANT_W-1] || (r_exp == '0)) w_next = DONE;
            DONE: if (i_out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_mant      <= '0;
            r_exp       <= '0;
            r_swap      <= 1'b0;
            r_zero      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_a   <= i_a_mant;
                        r_b   <= i_b_mant;
                        r_exp <= i_exp_in;
                    end
                end
                SUB: begin
                    r_underflow <= 1'b0;
                    if (w_diff == '0) begin
                        r_mant <= '0;
                        r_exp  <= '0;
                        r_swap <= 1'b0;
                        r_zero <= 1'b1;
                    end else begin
                        r_mant <= w_diff;
                        r_swap <= w_borrow;
                        r_zero <= 1'b0;
                    end
                end
                NORM: begin
                    // Stop at exponent 0 leaving a denormal rather than wrapping.
                    if (!r_mant[MANT_W-1]) begin
                        if (r_exp == '0) begin
                            r_underflow <= 1'b1;
                        end else begin
                            r_mant <= {r_mant[MANT_W-2:0], 1'b0};
                            r_exp  <= r_exp - EXP_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE) && !i_rst;
    assign o_out_valid = (r_state == DONE);
    assign o_diff_mant = r_mant;
    assign o_exp_out   = r_exp;
    assign o_swap      = r_swap;
    assign o_zero      = r_zero;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_mantissa_sub_normalizer.sv
// Directed and random checks of mantissa_sub_normalizer against an arithmetic model.
module tb_mantissa_sub_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [23:0] a_mant, b_mant;
    logic [7:0]  exp_in;
    logic        out_valid, out_ready;
    logic [23:0] diff_mant;
    logic [7:0]  exp_out;
    logic        swap, zero, underflow;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mantissa_sub_normalizer dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a_mant(a_mant), .i_b_mant(b_mant), .i_exp_in(exp_in),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_diff_mant(diff_mant), .o_exp_out(exp_out),
        .o_swap(swap), .o_zero(zero), .o_underflow(underflow)
    );

    typedef struct {
        int unsigned m;
        int unsigned e;
        int unsigned s;
        int unsigned z;
        int unsigned u;
        int unsigned lat;
    } res_t;

    // Plain-integer view of the operation: magnitude, then shift until the
    // leading bit reaches bit 23 or the exponent runs out.
    function automatic res_t model(int unsigned a, int unsigned b, int unsigned e);
        res_t r;
        int unsigned d, k;
        d = (a >= b) ? a - b : b - a;
        if (d == 0) begin
            r.m = 0; r.e = 0; r.s = 0; r.z = 1; r.u = 0; r.lat = 1;
        end else begin
            k = 0;
            while (d < 32'h80_0000 && e > 0) begin
                d = d * 2;
                e = e - 1;
                k++;
            end
            r.m = d; r.e = e; r.s = (b > a) ? 1 : 0; r.z = 0;
            r.u = (d < 32'h80_0000) ? 1 : 0;
            r.lat = 2 + k;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_mant"}, 32'(diff_mant), 32'd0);
        chk({tag, "_exp"}, 32'(exp_out), 32'd0);
        chk({tag, "_flags"}, 32'({swap, zero, underflow}), 32'd0);
    endtask

    // Called #1 after the acceptance edge; counts edges until out_valid.
    task automatic wait_and_check(input string tag, input int unsigned a,
                                  input int unsigned b, input int unsigned e);
        res_t r;
        int cyc;
        r = model(a, b, e);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(r.lat));
        chk({tag, "_mant"}, 32'(diff_mant), r.m);
        chk({tag, "_exp"}, 32'(exp_out), r.e);
        chk({tag, "_swap"}, 32'(swap), r.s);
        chk({tag, "_zero"}, 32'(zero), r.z);
        chk({tag, "_uf"}, 32'(underflow), r.u);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input int unsigned a,
                          input int unsigned b, input int unsigned e);
        @(negedge clk);
        a_mant = 24'(a); b_mant = 24'(b); exp_in = 8'(e);
        in_valid = 1'b1;
        chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_and_check(tag, a, b, e);
        drain(tag);
    endtask

    initial begin
        logic [23:0] hold_m;
        logic [7:0]  hold_e;
        logic [2:0]  hold_f;
        int unsigned ra, rb, re;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_mant = '0; b_mant = '0; exp_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        chk("reset_inrdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_inrdy", 32'(in_ready), 32'd1);

        run_op("c1", 32'h80_0000, 32'h40_0000, 32'h80);
        run_op("c2", 32'h40_0000, 32'h80_0000, 32'h80);
        run_op("c3", 32'hAB_CDEF, 32'hAB_CDEF, 32'h55);
        run_op("c4", 32'h80_0001, 32'h80_0000, 32'h10);
        run_op("exp0", 32'h00_0003, 32'h00_0001, 32'h00);
        run_op("full", 32'hFF_FFFF, 32'h00_0000, 32'h01);

        // Backpressure: hold DONE while new operands are offered.
        @(negedge clk);
        a_mant = 24'h80_0000; b_mant = 24'h40_0000; exp_in = 8'h80; in_valid = 1'b1;
        @(posedge clk); #1;
        wait_and_check("bp", 32'h80_0000, 32'h40_0000, 32'h80);
        hold_m = diff_mant; hold_e = exp_out; hold_f = {swap, zero, underflow};
        @(negedge clk);
        a_mant = 24'h12_3456; b_mant = 24'h65_4321; exp_in = 8'h40; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_inrdy", 32'(in_ready), 32'd0);
            chk("bp_mant", 32'(diff_mant), 32'(hold_m));
            chk("bp_exp", 32'(exp_out), 32'(hold_e));
            chk("bp_flags", 32'(({swap, zero, underflow})), 32'(hold_f));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_inrdy", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp_taken", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_and_check("bp_new", 32'h12_3456, 32'h65_4321, 32'h40);
        drain("bp_new");

        // Reset in the middle of normalization aborts without a result beat.
        @(negedge clk);
        a_mant = 24'h80_0001; b_mant = 24'h80_0000; exp_in = 8'h10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero_outputs("midrst");
        chk("midrst_inrdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release", 32'(in_ready), 32'd1);
        run_op("after_rst", 32'h80_0000, 32'h40_0000, 32'h80);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom & 32'hFF_FFFF;
            case ($urandom_range(0, 3))
                0: rb = $urandom & 32'hFF_FFFF;
                1: rb = ra ^ ($urandom & 32'hFF);
                2: rb = ra;
                default: rb = ra >> $urandom_range(0, 23);
            endcase
            re = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : $urandom_range(0, 255);
            run_op("rand", ra, rb, re);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mantissa_sub_normalizer.md
Name: mantissa_sub_normalizer

Overview:
Iterative subtract-and-normalize unit for the FP adder's effective-subtraction path, the inverse operation of the mantissa carry-lookahead add path. It accepts two 24-bit significands sharing a common (already aligned) exponent. It computes the magnitude of their difference with a flag when operands were swapped, then left-normalizes one bit per cycle while decrementing the exponent. Valid/ready handshake on both sides; one operation in flight.

Parameters:
MANT_W, 24, significand width including hidden bit (MSB = bit MANT_W-1)
EXP_W, 8, exponent width (unsigned, biased)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept operands
a_mant  in  MANT_W  minuend significand
b_mant  in  MANT_W  subtrahend significand
exp_in  in  EXP_W  common aligned exponent
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
diff_mant  out  MANT_W  normalized |a-b|
exp_out  out  EXP_W  adjusted exponent
swap  out  1  1 when b_mant > a_mant (result sign inverted)
zero  out  1  1 when a_mant == b_mant
underflow  out  1  exponent hit 0 before MSB set (denormal result)

Behaviour:
- Reset: synchronous. On a clock edge with rst=1, state goes to IDLE and all outputs and registers go to 0. in_ready=0 while rst is high and 1 in the first cycle after release. Reset in any state aborts the operation with no output beat.
- FSM states: IDLE, SUB, NORM, DONE. in_ready = (state==IDLE), combinational. out_valid = (state==DONE), registered state.
- IDLE: on edge with in_valid=1, latch a_mant, b_mant, exp_in and go to SUB. Otherwise stay.
- SUB (exactly 1 cycle):
  - Compute a + ~b + 1 in MANT_W+1 bits; carry-out 0 means borrow.
  - On borrow: mant = b - a, swap = 1. Else mant = a - b, swap = 0.
  - If mant == 0: zero = 1, diff_mant = 0, exp_out = 0, swap = 0, go to DONE.
  - Otherwise load the working mant/exp registers and go to NORM.
- NORM, evaluated once per edge, in priority order:
  - mant[MSB]=1: go to DONE.
  - else exp==0: underflow = 1, go to DONE with mant unshifted.
  - else mant <<= 1 (zero fill), exp -= 1, stay in NORM.
- Latency: acceptance edge E0. Zero result gives out_valid after E1. Otherwise out_valid after E(2+k), where k = number of shifts, 0..MANT_W-1.
- DONE: diff_mant, exp_out, swap, zero and underflow stay stable while out_valid=1. On an edge with out_ready=1, go to IDLE; out_valid drops and flags hold their values until the next SUB.
- Backpressure: in_valid is ignored outside IDLE, and operands are not consumed. No combinational path from in_* to out_*.
- Arithmetic: exp never wraps below 0. diff_mant always fits MANT_W because |a-b| <= max(a,b).
- Simultaneous events: rst has priority over every handshake. out_ready high in DONE and in_valid high in the same cycle gives IDLE; the new beat is accepted on the following edge, so there is no same-cycle turnaround.

Test Plan:
- a=0x800000, b=0x400000, exp=0x80 -> k=1; diff_mant=0x800000, exp_out=0x7F, swap=0, zero=0, underflow=0; out_valid after E3.
- a=0x400000, b=0x800000, exp=0x80 -> same diff_mant/exp_out as above, swap=1.
- a=b=0xABCDEF, exp=0x55 -> zero=1, diff_mant=0, exp_out=0, swap=0; out_valid after E1.
- a=0x800001, b=0x800000, exp=0x10 -> 16 shifts then underflow=1; diff_mant=0x010000, exp_out=0; out_valid after E18.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not taken. Raise out_ready -> IDLE, then new beat accepted the next edge.
- Assert rst for 1 cycle during NORM of case 4 -> next cycle out_valid=0 and all outputs 0; in_ready=1 after release; a fresh case 1 then completes correctly.
